// File: rtl/step_dir_generator_pkg.sv
// Shared definitions for the step/dir generator: FSM state encoding and default widths.
package step_dir_generator_pkg;

  localparam int CNT_W_DEF     = 32;
  localparam int TMR_W_DEF     = 16;
  localparam int POS_W_DEF     = 32;
  localparam int DIR_SETUP_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/step_dir_generator_timer.sv
// Loadable down-counter shared by the SETUP, HIGH and LOW phases.
// Loading L gives a phase of L+1 cycles; expire is high on the last one.
module step_dir_generator_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expire
);

  logic [TMR_W-1:0] cnt_r;

  // Countdown register: reload on phase entry, otherwise count toward zero and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {TMR_W{1'b0}}) begin
      cnt_r <= cnt_r - TMR_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == {TMR_W{1'b0}});

endmodule

// File: rtl/step_dir_generator.sv
// Step/dir pulse generator: accepts one move at a time and emits the commanded
// step train with dir setup, tracking remaining steps and signed position.
module step_dir_generator
  import step_dir_generator_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int TMR_W         = TMR_W_DEF,
  parameter int POS_W         = POS_W_DEF,
  parameter int DIR_SETUP_CYC = DIR_SETUP_DEF
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_dir,
  input  logic [TMR_W-1:0] cmd_period,
  input  logic [TMR_W-1:0] cmd_pulse_w,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             move_done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_remaining,
  output logic [POS_W-1:0] position
);

  localparam logic [TMR_W-1:0] SETUP_M1 = TMR_W'(DIR_SETUP_CYC - 1);

  function automatic logic [TMR_W-1:0] pw_eff_f(input logic [TMR_W-1:0] pw);
    pw_eff_f = (pw == {TMR_W{1'b0}}) ? TMR_W'(1) : pw;
  endfunction

  // Low-phase length minus one; kept in TMR_W bits so pw_eff+1 never needs a wider field.
  function automatic logic [TMR_W-1:0] low_m1_f(input logic [TMR_W-1:0] per,
                                                 input logic [TMR_W-1:0] pw_eff);
    low_m1_f = (per > pw_eff) ? (per - pw_eff - TMR_W'(1)) : {TMR_W{1'b0}};
  endfunction

  state_e           state_r, next_state_s;
  logic [TMR_W-1:0] pw_m1_r, low_m1_r, tmr_load_val_s;
  logic             tmr_load_s, tmr_expire_s;
  logic             abort_r, abort_eff_s, accept_s, enter_high_s;
  logic             step_r, dir_r, busy_r, move_done_r, aborted_r, cmd_ready_r;
  logic [CNT_W-1:0] steps_rem_r;
  logic [POS_W-1:0] position_r;

  assign accept_s     = cmd_valid & (state_r == ST_IDLE);
  assign abort_eff_s  = (state_r != ST_IDLE) & (abort | abort_r);
  assign enter_high_s = (next_state_s == ST_HIGH) & (state_r != ST_HIGH);

  step_dir_generator_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (CLK),
    .rst_n    (resetn),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .expire   (tmr_expire_s)
  );

  // State register.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = (cmd_count == {CNT_W{1'b0}}) ? ST_DONE : ST_SETUP;
        else          next_state_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (abort_eff_s)       next_state_s = ST_DONE;
        else if (tmr_expire_s) next_state_s = ST_HIGH;
        else                   next_state_s = ST_SETUP;
      end
      ST_HIGH: begin
        if (tmr_expire_s) next_state_s = abort_eff_s ? ST_DONE : ST_LOW;
        else              next_state_s = ST_HIGH;
      end
      ST_LOW: begin
        if (abort_eff_s)       next_state_s = ST_DONE;
        else if (tmr_expire_s) next_state_s = (steps_rem_r == {CNT_W{1'b0}}) ? ST_DONE : ST_HIGH;
        else                   next_state_s = ST_LOW;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Timer reload on every phase entry with that phase's length.
  always_comb begin
    tmr_load_s     = 1'b0;
    tmr_load_val_s = {TMR_W{1'b0}};
    if (next_state_s != state_r) begin
      tmr_load_s = 1'b1;
      case (next_state_s)
        ST_SETUP: tmr_load_val_s = SETUP_M1;
        ST_HIGH:  tmr_load_val_s = pw_m1_r;
        ST_LOW:   tmr_load_val_s = low_m1_r;
        default:  tmr_load_val_s = {TMR_W{1'b0}};
      endcase
    end else begin
      tmr_load_s = 1'b0;
    end
  end

  // Command capture and abort latch (abort only counts once a move is running).
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      pw_m1_r  <= {TMR_W{1'b0}};
      low_m1_r <= {TMR_W{1'b0}};
      abort_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        pw_m1_r  <= pw_eff_f(cmd_pulse_w) - TMR_W'(1);
        low_m1_r <= low_m1_f(cmd_period, pw_eff_f(cmd_pulse_w));
      end
      if (state_r == ST_IDLE || state_r == ST_DONE) abort_r <= 1'b0;
      else if (abort)                               abort_r <= 1'b1;
    end
  end

  // Registered outputs, steps_remaining and position.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      step_r      <= 1'b0;
      dir_r       <= 1'b0;
      busy_r      <= 1'b0;
      move_done_r <= 1'b0;
      aborted_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      steps_rem_r <= {CNT_W{1'b0}};
      position_r  <= {POS_W{1'b0}};
    end else begin
      step_r      <= (next_state_s == ST_HIGH);
      busy_r      <= (next_state_s != ST_IDLE);
      move_done_r <= (next_state_s == ST_DONE);
      aborted_r   <= (next_state_s == ST_DONE) & abort_eff_s;
      cmd_ready_r <= (next_state_s == ST_IDLE);
      if (accept_s) begin
        dir_r       <= cmd_dir;
        steps_rem_r <= cmd_count;
      end else if (enter_high_s && steps_rem_r != {CNT_W{1'b0}}) begin
        steps_rem_r <= steps_rem_r - CNT_W'(1);
        position_r  <= position_r + (dir_r ? POS_W'(1) : {POS_W{1'b1}});
      end
    end
  end

  assign step            = step_r;
  assign dir             = dir_r;
  assign busy            = busy_r;
  assign move_done       = move_done_r;
  assign aborted         = aborted_r;
  assign cmd_ready       = cmd_ready_r;
  assign steps_remaining = steps_rem_r;
  assign position        = position_r;

endmodule

// File: doc/step_dir_generator.md
# step_dir_generator

Motion-command front end that produces the step/dir pulse train consumed by the H-bridge phase sequencer. It accepts one move at a time over a valid/ready handshake and emits exactly the commanded number of step pulses. Each command carries direction, step period and pulse width; direction setup time is honoured before the first pulse. It also tracks remaining steps and an absolute signed position, and supports a clean abort that never truncates a pulse.

## Interface

- CNT_W, 32: width of step count and steps_remaining.
- TMR_W, 16: width of period and pulse-width fields, in clock cycles.
- POS_W, 32: width of the signed position counter.
- DIR_SETUP_CYC, 4: cycles between the dir update and the first step rise; must be ≥1.
- CLK  input  1  system clock; single domain.
- resetn  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_count  input  CNT_W  number of steps to emit.
- cmd_dir  input  1  direction; 1 increments position.
- cmd_period  input  TMR_W  step rise-to-rise period in cycles.
- cmd_pulse_w  input  TMR_W  step high time in cycles.
- abort  input  1  synchronous request to stop the current move.
- step  output  1  step pulse to the phase sequencer.
- dir  output  1  direction to the phase sequencer.
- busy  output  1  move in progress; high in any state other than IDLE.
- move_done  output  1  one-cycle strobe at the end of a move.
- aborted  output  1  valid with move_done; set when the move ended by abort.
- steps_remaining  output  CNT_W  steps still to emit.
- position  output  POS_W  signed absolute step position.

## Operation

- Reset values: step=0, dir=0, busy=0, move_done=0, aborted=0, steps_remaining=0, position=0, cmd_ready=1 (state IDLE).
- States:
  - IDLE
  - SETUP: dir settle time.
  - HIGH: step=1.
  - LOW: step=0.
  - DONE: move_done=1, single cycle.
- Accept: on a cycle with cmd_valid & cmd_ready, the block latches count, dir, pw_eff and per_eff. In the same edge it loads dir and steps_remaining=cmd_count.
  - pw_eff = max(cmd_pulse_w, 1).
  - per_eff = max(cmd_period, pw_eff+1).
- cmd_count==0: IDLE goes to DONE, with no pulse and no dir setup. dir is still updated.
- Otherwise IDLE goes to SETUP, which runs for DIR_SETUP_CYC cycles, then goes to HIGH.
- Entering HIGH (the step rising edge):
  - steps_remaining decrements by 1.
  - position increments by 1 if dir=1, decrements by 1 if dir=0.
- HIGH runs pw_eff cycles, then goes to LOW. LOW runs per_eff−pw_eff cycles.
- At the end of LOW:
  - if steps_remaining==0 or an abort is latched, go to DONE;
  - else go to HIGH.
- DONE lasts one cycle, asserting move_done and aborted, then returns to IDLE.
- Abort handling:
  - abort is sampled in every non-IDLE state and latched until DONE.
  - In SETUP: go to DONE immediately, with no pulse.
  - In HIGH: finish the high time, then go straight to DONE. The trailing low time is skipped, so there is no runt pulse.
  - In LOW: go to DONE on the next edge.
  - steps_remaining keeps its value at the abort.
- abort in IDLE is ignored and is not latched.
- dir changes only on a command accept; it is never changed mid-move.
- Arithmetic:
  - position wraps modulo 2^POS_W, two's complement.
  - steps_remaining never underflows.
- cmd_valid while busy: held off by cmd_ready=0. The command must stay stable until accepted.

## Timing

- Accept at edge T0 with count=N:
  - dir is valid from T0.
  - First step rise at T0+DIR_SETUP_CYC.
  - Rise-to-rise spacing is per_eff.
  - Last fall at T0+DIR_SETUP_CYC+(N−1)·per_eff+pw_eff.
  - move_done is high for the cycle starting at T0+DIR_SETUP_CYC+N·per_eff.
  - cmd_ready returns one cycle later.
- count=0: move_done is high for the cycle starting at T0; cmd_ready rises at T0+1.
- Back-to-back: minimum gap between moves is one IDLE cycle after DONE. The next accept can occur on that IDLE cycle.
- step, dir and all status outputs are registered, with no combinational path from inputs.

## Structure

- Shared include stepgen_defs.v holds the state encoding localparams (IDLE, SETUP, HIGH, LOW, DONE) and the default widths.
- One sub-module, stepgen_timer: a loadable TMR_W down-counter with a load input and an expire strobe. The same timer is reused for SETUP, HIGH and LOW.
- Top level holds the FSM, command registers, steps_remaining and position.

## Test plan

- Reset mid-move (resetn low during HIGH) -> step=0, position=0, busy=0 asynchronously; cmd_ready=1 after release.
- count=3, dir=1, period=10, pulse_w=3, DIR_SETUP_CYC=4 -> rises at T0+4, +14, +24; each high 3 cycles; position=3; move_done at T0+34.
- count=2, dir=0, period=2, pulse_w=5 -> pw_eff=5, per_eff=6; position=−2 (all-ones); no overlapping pulses.
- count=0 -> no step; move_done at T0; aborted=0; position unchanged.
- count=100, abort asserted in HIGH of step 5 -> pulse completes its full width; move_done next cycle with aborted=1; steps_remaining=95; position=5.
- position at 2^31−1, count=1, dir=1 -> position wraps to −2^31.
